simplez_bus: RTL and testbench



---
 rtl/simplez_bus_if.sv | 23 ++
 rtl/simplez_bus.sv | 162 ++++++++++++++++
 tb/tb_simplez_bus.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simplez_bus_if.sv
// Request/acknowledge bus between the Simplez core and its slaves.
// The slave may hold bus_ack low to insert wait states.
interface simplez_bus_if #(
    parameter int DW = 12,
    parameter int AW = 9
);
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/simplez_bus.sv
// Parametrised Simplez core with a wait-state bus and run/step debug control.
// Instructions are 3-bit opcode plus an AW-bit operand address.
module simplez_bus #(
    parameter int DW          = 12,
    parameter int AW          = 9,
    parameter int WAIT_CYCLES = 2400000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          step,
    simplez_bus_if.master bus,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic          zflag,
    output logic          halted
);

    localparam logic [2:0] OP_ST  = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_BR  = 3'd3;
    localparam logic [2:0] OP_BZ  = 3'd4;
    localparam logic [2:0] OP_CLR = 3'd5;
    localparam logic [2:0] OP_DEC = 3'd6;

    localparam logic [31:0] WAIT_M1 = 32'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WAITS,
        S_HALTED
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] ir, ir_nx;
    logic [DW-1:0] acc_nx;
    logic [AW-1:0] pc_nx;
    logic          zflag_nx;
    logic          halted_nx;
    logic [31:0]   cnt, cnt_nx;
    logic          acc_wr;

    logic [2:0]    co;
    logic [AW-1:0] cd;
    logic          sub;
    logic [AW-1:0] pc_inc;

    assign co     = ir[DW-1 -: 3];
    assign cd     = ir[AW-1:0];
    assign sub    = ir[DW-4];
    assign pc_inc = pc + AW'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_IDLE;
            ir     <= '0;
            pc     <= '0;
            acc    <= '0;
            zflag  <= 1'b0;
            halted <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            ir     <= ir_nx;
            pc     <= pc_nx;
            acc    <= acc_nx;
            zflag  <= zflag_nx;
            halted <= halted_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ir_nx     = ir;
        pc_nx     = pc;
        acc_nx    = acc;
        zflag_nx  = zflag;
        halted_nx = halted;
        cnt_nx    = cnt;
        acc_wr    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (run || step) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (bus.bus_ack) begin
                    ir_nx    = bus.bus_rdata;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = S_IDLE;
                unique case (co)
                    OP_ST, OP_LD, OP_ADD: state_nx = S_MEM;
                    OP_BR: pc_nx = cd;
                    OP_BZ: pc_nx = zflag ? cd : pc_inc;
                    OP_CLR: begin
                        acc_nx = '0;
                        acc_wr = 1'b1;
                        pc_nx  = pc_inc;
                    end
                    OP_DEC: begin
                        acc_nx = acc - DW'(1);
                        acc_wr = 1'b1;
                        pc_nx  = pc_inc;
                    end
                    default: begin
                        if (sub) begin
                            cnt_nx   = WAIT_M1;
                            state_nx = S_WAITS;
                        end else begin
                            halted_nx = 1'b1;
                            state_nx  = S_HALTED;
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (bus.bus_ack) begin
                    pc_nx    = pc_inc;
                    state_nx = S_IDLE;
                    if (co == OP_LD) begin
                        acc_nx = bus.bus_rdata;
                        acc_wr = 1'b1;
                    end else if (co == OP_ADD) begin
                        acc_nx = acc + bus.bus_rdata;
                        acc_wr = 1'b1;
                    end
                end
            end
            S_WAITS: begin
                if (cnt == '0) begin
                    pc_nx    = pc_inc;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            S_HALTED: begin
                state_nx = S_HALTED;
            end
            default: state_nx = S_IDLE;
        endcase

        if (acc_wr) zflag_nx = (acc_nx == '0);
    end

    // Bus outputs depend only on registered state, so they hold steady
    // for as long as the slave stretches the access.
    assign bus.bus_req   = (state == S_FETCH) || (state == S_MEM);
    assign bus.bus_we    = (state == S_MEM) && (co == OP_ST);
    assign bus.bus_addr  = (state == S_MEM)   ? cd :
                           (state == S_FETCH) ? pc : '0;
    assign bus.bus_wdata = acc;

endmodule

// File: tb/tb_simplez_bus.sv
// Bench for simplez_bus: memory slave with wait states on the data region,
// expected writes queued up front and matched as the core writes.
module tb_simplez_bus;

    localparam int DW = 12;
    localparam int AW = 9;
    localparam int WC = 5;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          run  = 1'b0;
    logic          step = 1'b0;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          zflag;
    logic          halted;

    simplez_bus_if #(.DW(DW), .AW(AW)) bif ();

    simplez_bus #(.DW(DW), .AW(AW), .WAIT_CYCLES(WC)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .step   (step),
        .bus    (bif),
        .pc     (pc),
        .acc    (acc),
        .zflag  (zflag),
        .halted (halted)
    );

    logic        run2 = 1'b0;
    logic [11:0] pc2;
    logic [15:0] acc2;
    logic        zflag2;
    logic        halted2;

    simplez_bus_if #(.DW(16), .AW(12)) bif2 ();

    simplez_bus #(.DW(16), .AW(12), .WAIT_CYCLES(3)) dut2 (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run2),
        .step   (1'b0),
        .bus    (bif2),
        .pc     (pc2),
        .acc    (acc2),
        .zflag  (zflag2),
        .halted (halted2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [11:0] mem  [0:511];
    logic [15:0] mem2 [0:4095];
    int          ws   = 0;
    logic [7:0]  wcnt = '0;

    assign bif.bus_rdata = mem[bif.bus_addr];
    assign bif.bus_ack   = bif.bus_req &&
                           (bif.bus_addr < 9'h100 || wcnt == 8'(ws));
    assign bif2.bus_rdata = mem2[bif2.bus_addr];
    assign bif2.bus_ack   = bif2.bus_req;

    always @(posedge clk) begin
        if (!bif.bus_req || bif.bus_ack) wcnt <= '0;
        else wcnt <= wcnt + 8'd1;
    end

    typedef struct packed {
        logic [8:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t wq[$];

    always @(negedge clk) begin
        wr_t e;
        if (bif.bus_req && bif.bus_ack && bif.bus_we) begin
            check("wr_pending", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("wr_addr", 32'(bif.bus_addr), 32'(e.a));
                check("wr_data", 32'(bif.bus_wdata), 32'(e.d));
            end
            mem[bif.bus_addr] = bif.bus_wdata;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step_instr(input string tag, input logic [8:0] ra,
                              output int cyc, output int reqc,
                              output int reqa);
        logic [8:0] p0;
        logic       done;
        cyc  = 0;
        reqc = 0;
        reqa = 0;
        done = 1'b0;
        @(negedge clk);
        p0   = pc;
        step = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            step = 1'b0;
            cyc++;
            if (bif.bus_req) reqc++;
            if (bif.bus_req && bif.bus_addr == ra) reqa++;
            if (pc != p0 || halted) done = 1'b1;
        end
        check({tag, "_retired"}, 32'(done), 32'd1);
    endtask

    logic [8:0] bpc [6] = '{9'h001, 9'h010, 9'h011, 9'h012, 9'h1FF, 9'h000};
    int c, r, a;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 12'hA00;
        for (int i = 0; i < 4096; i++) mem2[i] = 16'hA000;
        mem2[0]     = 16'hC000;
        mem2[1]     = 16'h4800;
        mem2[2]     = 16'hE000;
        mem2[12'h800] = 16'h0001;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_zflag", 32'(zflag), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req", 32'(bif.bus_req), 32'd0);
        check("rst_we", 32'(bif.bus_we), 32'd0);
        check("rst_addr", 32'(bif.bus_addr), 32'd0);

        // CLR; DEC; ST 0x100; HALT free-running
        mem[0] = 12'hA00;
        mem[1] = 12'hC00;
        mem[2] = 12'h100;
        mem[3] = 12'hE00;
        wq.push_back('{a: 9'h100, d: 12'hFFF});
        @(negedge clk);
        rstn = 1'b1;
        run  = 1'b1;
        run2 = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        check("t1_halted", 32'(halted), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_pc", 32'(pc), 32'h3);
        check("t1_acc", 32'(acc), 32'hFFF);
        check("t1_zflag", 32'(zflag), 32'd0);
        check("t1_req_low", 32'(bif.bus_req), 32'd0);
        check("t1_mem", 32'(mem[9'h100]), 32'hFFF);
        check("t1_wq_empty", 32'(wq.size()), 32'd0);

        // wide instance: DEC; ADD 0x800 (=1); HALT
        check("w_halted", 32'(halted2), 32'd1);
        check("w_acc", 32'(acc2), 32'd0);
        check("w_zflag", 32'(zflag2), 32'd1);
        check("w_pc", 32'(pc2), 32'h2);
        run2 = 1'b0;

        // LD from a 3-wait-state slave
        run = 1'b0;
        do_reset();
        mem[0]      = 12'hC00;
        mem[1]      = 12'h305;
        mem[9'h105] = 12'h000;
        ws = 3;
        step_instr("dec", 9'h0, c, r, a);
        check("ld_pre_zflag", 32'(zflag), 32'd0);
        step_instr("ld", 9'h105, c, r, a);
        check("ld_cycles", 32'(c), 32'd7);
        check("ld_addr_hold", 32'(a), 32'd4);
        check("ld_req_cycles", 32'(r), 32'd5);
        check("ld_acc", 32'(acc), 32'd0);
        check("ld_zflag", 32'(zflag), 32'd1);
        check("ld_pc", 32'(pc), 32'h2);

        // branches and pc wrap
        ws = 0;
        do_reset();
        mem[0]      = 12'hA00;
        mem[1]      = 12'h810;
        mem[9'h010] = 12'hC00;
        mem[9'h011] = 12'h820;
        mem[9'h012] = 12'h7FF;
        mem[9'h1FF] = 12'h600;
        for (int i = 0; i < 6; i++) begin
            step_instr("br", 9'h0, c, r, a);
            check("br_pc", 32'(pc), 32'(bpc[i]));
            check("br_cycles", 32'(c), 32'd3);
        end
        mem[0]      = 12'h7FF;
        mem[9'h1FF] = 12'hC00;
        step_instr("br2", 9'h0, c, r, a);
        check("br2_pc", 32'(pc), 32'h1FF);
        step_instr("wrap", 9'h0, c, r, a);
        check("wrap_pc", 32'(pc), 32'h0);
        check("wrap_acc", 32'(acc), 32'hFFE);

        // step held through FETCH and EXEC must retire one instruction each
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 12'hC00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step = 1'b1;
            repeat (3) @(negedge clk);
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("step_pc", 32'(pc), 32'h3);
        check("step_acc", 32'(acc), 32'hFFD);
        repeat (10) @(negedge clk);
        check("step_idle_pc", 32'(pc), 32'h3);

        // WAIT
        do_reset();
        mem[0] = 12'hF00;
        step_instr("wait", 9'h0, c, r, a);
        check("wait_cycles", 32'(c), 32'(3 + WC));
        check("wait_req_cycles", 32'(r), 32'd1);
        check("wait_pc", 32'(pc), 32'h1);
        check("wait_zflag", 32'(zflag), 32'd0);

        // reset in the middle of a stretched write
        do_reset();
        ws = 20;
        mem[0]      = 12'hC00;
        mem[1]      = 12'h100;
        mem[9'h100] = 12'h123;
        step_instr("pre_st", 9'h0, c, r, a);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 20 && !(bif.bus_req && bif.bus_we); i++)
            @(negedge clk);
        check("rm_write_seen", 32'(bif.bus_req && bif.bus_we), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rm_req", 32'(bif.bus_req), 32'd0);
        check("rm_we", 32'(bif.bus_we), 32'd0);
        check("rm_addr", 32'(bif.bus_addr), 32'd0);
        check("rm_pc", 32'(pc), 32'd0);
        check("rm_acc", 32'(acc), 32'd0);
        check("rm_zflag", 32'(zflag), 32'd0);
        check("rm_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("rm_mem_kept", 32'(mem[9'h100]), 32'h123);
        rstn = 1'b1;
        ws   = 0;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        check("rm_fetch_req", 32'(bif.bus_req), 32'd1);
        check("rm_fetch_addr", 32'(bif.bus_addr), 32'd0);
        repeat (4) @(negedge clk);
        check("rm_acc_after", 32'(acc), 32'hFFF);
        check("wq_final", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
